mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 256x8 memory between two requesters: port 0 (CPU core) and port 1
//  (program loader / debug master). Round-robin grant with a bounded burst length, so neither
//  port starves. Sits between the requesters and memory_256x8. Drives the memory's we/addr/d_i
//  and returns d_o to both ports. Port 0 uses p0_wait to freeze the CPU state register.
// PARAMETERS
//  ADDR_W     8  memory address width
//  DATA_W     8  memory data width
//  BURST_MAX  4  max consecutive granted cycles while the other port waits; legal range 1..15
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       reset, asynchronous, active-low
//  p0_req     in   1       port 0 access request (level, hold until served)
//  p0_we      in   1       port 0 write enable (1=write, 0=read)
//  p0_addr    in   ADDR_W  port 0 address
//  p0_wdata   in   DATA_W  port 0 write data
//  p0_gnt     out  1       port 0 owns memory this cycle
//  p0_wait    out  1       p0_req & ~p0_gnt (CPU stall)
//  p1_req/p1_we/p1_addr/p1_wdata/p1_gnt/p1_wait  same as port 0, for port 1
//  rdata      out  DATA_W  = mem_d_o, broadcast; valid only for the granted port
//  mem_we     out  1       to memory we
//  mem_addr   out  ADDR_W  to memory addr
//  mem_d_i    out  DATA_W  to memory d_i
//  mem_d_o    in   DATA_W  from memory (combinational read)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, p0_gnt=p1_gnt=0, last=1 (port 0 wins first tie),
//    burst_cnt=0. mem_we=0, mem_addr=0, mem_d_i=0 immediately; no write may occur in reset.
//  - States: IDLE, GRANT0, GRANT1. gnt bits are registered (one-hot decode of state).
//  - Latency: req seen at edge N with memory free -> gnt high from edge N+1.
//    A read's rdata is valid in the same cycle as gnt. A write commits at the edge that ends a
//    cycle with gnt_k & req_k & we_k.
//  - Memory mux: in GRANTk, mem_addr/mem_d_i = pk_addr/pk_wdata and mem_we = pk_we & pk_req.
//    In IDLE, all mem outputs are 0 and mem_we=0. A dropped req never writes.
//  - IDLE: only one req -> grant it. Both req -> grant port != last. None -> stay.
//  - GRANTk, pk_req=0: other req -> GRANTother directly (no idle bubble); else -> IDLE.
//  - GRANTk, pk_req=1, other req, burst_cnt==BURST_MAX-1 -> GRANTother (forced handover).
//  - GRANTk, pk_req=1 otherwise: stay; burst_cnt increments, saturating at BURST_MAX-1.
//  - burst_cnt clears to 0 on every state change. last updates to k on every entry to GRANTk.
//  - Sole requester is never preempted; burst limit applies only while the other port waits.
//  - BURST_MAX=1: with both requesting, grants alternate every cycle.
//  - Inputs of a non-granted port are ignored. Address wrap is the requester's concern.
//  - Reset mid-burst: gnt and mem_we drop asynchronously; the in-flight write is lost.
// STRUCTURE
//  - Shared package/header: state encodings ARB_IDLE=2'b00, ARB_G0=2'b01, ARB_G1=2'b10;
//    MEM_ADDR_W=8, MEM_DATA_W=8.
//  - One sub-module, arb_rr_pick: combinational next-owner select from
//    (req0, req1, last, state, burst_done).
//  - Parent holds the state/last/burst_cnt registers and the memory-port muxes.
// TESTING
//  1. rst=0 with p0_req=p1_req=1, p0_we=1 -> gnts 0, mem_we 0, memory contents unchanged.
//  2. Only p0_req, read addr 0x10 (mem=0xA5) -> p0_gnt at next edge, rdata=0xA5 that cycle,
//     p0_wait=1 only in the request cycle.
//  3. Both req from IDLE after reset -> port 0 granted first. Both held, BURST_MAX=4 ->
//     4 cycles port 0, then 4 cycles port 1, alternating.
//  4. Port 1 alone holds req 20 cycles -> p1_gnt stays high throughout, no preemption.
//  5. Port 0 writes 0x3C@0x80 while port 1 waits; port 0 drops req -> port 1 granted the next
//     cycle with no IDLE; port 1 reads 0x80 -> rdata=0x3C.
//  6. rst asserted mid-write burst of port 1 -> p1_gnt=0 and mem_we=0 the same cycle; after
//     release with both req, port 0 granted first (last=1).

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and widths for the two-port memory arbiter.
// The state codes double as the one-hot grant vector {gnt1, gnt0}.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_G0   = 2'b01,
    ARB_G1   = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational next-owner select for the two-port round-robin arbiter.
// When both ports request from IDLE, the winner is the port that was not granted last.
module arb_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last,
  input  arb_state_e i_state,
  input  logic       i_burst_done,
  output arb_state_e o_next
);

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    o_next = ARB_IDLE;
    unique case (i_state)
      ARB_IDLE: begin
        if (i_req0 && i_req1) o_next = i_last ? ARB_G0 : ARB_G1;
        else if (i_req0)      o_next = ARB_G0;
        else if (i_req1)      o_next = ARB_G1;
        else                  o_next = ARB_IDLE;
      end
      ARB_G0: begin
        if (!i_req0)                      o_next = i_req1 ? ARB_G1 : ARB_IDLE;
        else if (i_req1 && i_burst_done)  o_next = ARB_G1;
        else                              o_next = ARB_G0;
      end
      ARB_G1: begin
        if (!i_req1)                      o_next = i_req0 ? ARB_G0 : ARB_IDLE;
        else if (i_req0 && i_burst_done)  o_next = ARB_G0;
        else                              o_next = ARB_G1;
      end
      default: o_next = ARB_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a CPU port and a loader port.
// Grants are registered state; memory-side signals are a mux steered by that state.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int BURST_MAX = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_wait,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_wait,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_i,
  input  logic [DATA_W-1:0] mem_d_o
);

  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  arb_state_e r_state;
  arb_state_e w_next;
  logic       r_last;
  logic [3:0] r_burst_cnt;
  logic       w_burst_done;

  assign w_burst_done = (r_burst_cnt == BURST_LAST);

  arb_rr_pick u_pick (
    .i_req0       (p0_req),
    .i_req1       (p1_req),
    .i_last       (r_last),
    .i_state      (r_state),
    .i_burst_done (w_burst_done),
    .o_next       (w_next)
  );

  // NOTE: state is updated with non-blocking assignments and cleared by the
  // asynchronous reset, so grants and mem_we drop the moment rst goes low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ARB_IDLE;
      r_last      <= 1'b1;
      r_burst_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_burst_cnt <= '0;
      else if (r_state != ARB_IDLE && !w_burst_done)
        r_burst_cnt <= r_burst_cnt + 4'd1;
      if (w_next == ARB_G0)      r_last <= 1'b0;
      else if (w_next == ARB_G1) r_last <= 1'b1;
    end
  end

  assign p0_gnt  = r_state[0];
  assign p1_gnt  = r_state[1];
  assign p0_wait = p0_req & ~p0_gnt;
  assign p1_wait = p1_req & ~p1_gnt;
  assign rdata   = mem_d_o;

  // A dropped request inside a grant still holds the bus but never writes.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_d_i  = '0;
    unique case (r_state)
      ARB_G0: begin
        mem_we   = p0_we & p0_req;
        mem_addr = p0_addr;
        mem_d_i  = p0_wdata;
      end
      ARB_G1: begin
        mem_we   = p1_we & p1_req;
        mem_addr = p1_addr;
        mem_d_i  = p1_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one DUT with BURST_MAX=4 and one with BURST_MAX=1,
// each attached to its own behavioural 256x8 memory with combinational read.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  logic       p0_gnt, p0_wait, p1_gnt, p1_wait, mem_we;
  logic [7:0] rdata, mem_addr, mem_d_i, mem_d_o;
  logic       b_p0_gnt, b_p0_wait, b_p1_gnt, b_p1_wait, b_mem_we;
  logic [7:0] b_rdata, b_mem_addr, b_mem_d_i, b_mem_d_o;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we)   mem0[mem_addr]   <= mem_d_i;
  always @(posedge clk) if (b_mem_we) mem1[b_mem_addr] <= b_mem_d_i;
  assign mem_d_o   = mem0[mem_addr];
  assign b_mem_d_o = mem1[b_mem_addr];

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_wait(p0_wait),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_wait(p1_wait),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_d_i(mem_d_i),
    .mem_d_o(mem_d_o)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .BURST_MAX(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(b_p0_gnt), .p0_wait(b_p0_wait),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(b_p1_gnt), .p1_wait(b_p1_wait),
    .rdata(b_rdata), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_d_i(b_mem_d_i),
    .mem_d_o(b_mem_d_o)
  );

  task automatic drop_all();
    p0_req = 1'b0; p0_we = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h20; p0_wdata = 8'hFF;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h20; p1_wdata = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({p1_gnt, p0_gnt, mem_we} !== 3'b000 || mem_addr !== 8'h00 || mem_d_i !== 8'h00) begin
        fails++;
        $display("FAIL reset_outputs: gnt1/gnt0/we=%b addr=%h d_i=%h, need 000/00/00",
                 {p1_gnt, p0_gnt, mem_we}, mem_addr, mem_d_i);
      end
    end
    tests++;
    if (mem0[8'h20] !== 8'h11) begin
      fails++;
      $display("FAIL reset_no_write: mem[20]=%h, need 11", mem0[8'h20]);
    end
    drop_all();
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
    @(negedge clk);
    tests++;
    if (p0_gnt !== 1'b0 || p0_wait !== 1'b1) begin
      fails++;
      $display("FAIL read_req_cycle: gnt=%b wait=%b, need gnt=0 wait=1", p0_gnt, p0_wait);
    end
    @(negedge clk);
    tests++;
    if (p0_gnt !== 1'b1 || p0_wait !== 1'b0 || rdata !== 8'hA5 || mem_addr !== 8'h10) begin
      fails++;
      $display("FAIL read_gnt_cycle: gnt=%b wait=%b rdata=%h addr=%h, need 1 0 a5 10",
               p0_gnt, p0_wait, rdata, mem_addr);
    end
    @(posedge clk); #1;
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (p0_gnt !== 1'b0 || p0_wait !== 1'b0) begin
      fails++;
      $display("FAIL read_release: gnt=%b wait=%b, need 0 0", p0_gnt, p0_wait);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_a, exp_b;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h11;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_a = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
      exp_b = ((i % 2) == 0) ? 2'b01 : 2'b10;
      tests++;
      if ({p1_gnt, p0_gnt} !== exp_a || {b_p1_gnt, b_p0_gnt} !== exp_b) begin
        fails++;
        $display("FAIL rr_cycle%0d: burst4 gnt=%b need %b, burst1 gnt=%b need %b",
                 i, {p1_gnt, p0_gnt}, exp_a, {b_p1_gnt, b_p0_gnt}, exp_b);
      end
    end
    @(posedge clk); #1;
    drop_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sole_requester();
    @(posedge clk); #1;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h10;
    @(negedge clk);
    tests++;
    if (p1_gnt !== 1'b0 || p1_wait !== 1'b1) begin
      fails++;
      $display("FAIL sole_req_cycle: gnt=%b wait=%b, need 0 1", p1_gnt, p1_wait);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (p1_gnt !== 1'b1 || p1_wait !== 1'b0 || b_p1_gnt !== 1'b1) begin
        fails++;
        $display("FAIL sole_hold%0d: gnt=%b wait=%b burst1_gnt=%b, need 1 0 1",
                 i, p1_gnt, p1_wait, b_p1_gnt);
      end
    end
    @(posedge clk); #1;
    drop_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_handover_write_read();
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h80; p0_wdata = 8'h3C;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h80;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (p0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h80 || mem_d_i !== 8'h3C
        || p1_wait !== 1'b1) begin
      fails++;
      $display("FAIL wr_cycle: gnt0=%b we=%b addr=%h d_i=%h wait1=%b, need 1 1 80 3c 1",
               p0_gnt, mem_we, mem_addr, mem_d_i, p1_wait);
    end
    @(posedge clk); #1;
    p0_req = 1'b0;
    tests++;
    if (mem0[8'h80] !== 8'h3C) begin
      fails++;
      $display("FAIL wr_commit: mem[80]=%h, need 3c", mem0[8'h80]);
    end
    @(negedge clk);
    tests++;
    if (p0_gnt !== 1'b1 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL dropped_req: gnt0=%b we=%b, need 1 0", p0_gnt, mem_we);
    end
    @(negedge clk);
    tests++;
    if ({p1_gnt, p0_gnt} !== 2'b10 || rdata !== 8'h3C) begin
      fails++;
      $display("FAIL handover_read: gnt=%b rdata=%h, need 10 3c", {p1_gnt, p0_gnt}, rdata);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    p1_we = 1'b1; p1_addr = 8'h90; p1_wdata = 8'h77;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
    @(negedge clk);
    tests++;
    if (p1_gnt !== 1'b1 || mem_we !== 1'b1) begin
      fails++;
      $display("FAIL burst_write: gnt1=%b we=%b, need 1 1", p1_gnt, mem_we);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (p1_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h00) begin
      fails++;
      $display("FAIL async_drop: gnt1=%b we=%b addr=%h, need 0 0 00", p1_gnt, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    tests++;
    if (mem0[8'h90] !== 8'h5A) begin
      fails++;
      $display("FAIL lost_write: mem[90]=%h, need 5a", mem0[8'h90]);
    end
    p1_we = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({p1_gnt, p0_gnt} !== 2'b01 || {b_p1_gnt, b_p0_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL post_reset_tie: gnt=%b burst1_gnt=%b, need 01 01",
               {p1_gnt, p0_gnt}, {b_p1_gnt, b_p0_gnt});
    end
    @(posedge clk); #1;
    drop_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[8'h20] = 8'h11;
    mem0[8'h10] = 8'hA5;
    mem0[8'h90] = 8'h5A;
    mem1[8'h10] = 8'hA5;
    p0_addr = 8'h00; p0_wdata = 8'h00; p1_addr = 8'h00; p1_wdata = 8'h00;
    drop_all();

    test_reset();
    test_single_read();
    test_round_robin();
    test_sole_requester();
    test_handover_write_read();
    test_reset_mid_burst();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
